// File: rtl/ntsc_frame_writer_pkg.sv
// Shared constants, pairing-FSM state type and address helper for the NTSC frame writer.
package ntsc_frame_writer_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_FIFO_LOG = 3;
    localparam int DEF_ADDR_W   = 19;
    localparam int DEF_DATA_W   = 36;

    // One YCrCb pixel is {Y[7:0], Cr[4:0], Cb[4:0]}
    localparam int PIX_W = 18;
    localparam int X_W   = 10;
    localparam int Y_W   = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HAVE_LO,
        ST_PUSH
    } pair_state_t;

    // Word index of the pixel pair containing (x, y); two pixels per memory word.
    function automatic logic [31:0] word_index(input logic [X_W-1:0] x,
                                               input logic [Y_W-1:0] y,
                                               input int unsigned    half_line);
        return 32'(y) * half_line + 32'(x[X_W-1:1]);
    endfunction

endpackage

// File: rtl/ntsc_write_fifo.sv
// Synchronous FIFO holding packed {last_tag, addr, data} entries for the frame writer.
module ntsc_write_fifo #(
    parameter int WIDTH    = 56,
    parameter int FIFO_LOG = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [WIDTH-1:0]  i_data,
    output logic [WIDTH-1:0]  o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [FIFO_LOG:0] o_count
);
    localparam int DEPTH = 1 << FIFO_LOG;
    localparam logic [FIFO_LOG:0] DEPTH_C = (FIFO_LOG + 1)'(DEPTH);

    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [FIFO_LOG-1:0] r_wr_ptr;
    logic [FIFO_LOG-1:0] r_rd_ptr;
    logic [FIFO_LOG:0]   r_count;
    logic                w_do_push;
    logic                w_do_pop;

    assign o_full    = (r_count == DEPTH_C);
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    // A full FIFO still takes a word when the head leaves in the same cycle
    assign w_do_push = i_push && (!o_full || w_do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push)
                r_wr_ptr <= r_wr_ptr + FIFO_LOG'(1);
            if (w_do_pop)
                r_rd_ptr <= r_rd_ptr + FIFO_LOG'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + (FIFO_LOG + 1)'(1);
                2'b01:   r_count <= r_count - (FIFO_LOG + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (w_do_push)
            r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/ntsc_frame_writer.sv
// Packs camera pixel pairs into 36-bit ZBT words and drains them to the arbiter via flag/done.
// Define NTSC_WRITE_DOUBLE_BUFFER_EN to alternate frames between two banks and expose display_bank.
module ntsc_frame_writer
    import ntsc_frame_writer_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int FIFO_LOG = DEF_FIFO_LOG,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pix_valid,
    input  logic [PIX_W-1:0]  pix_ycrcb,
    input  logic [X_W-1:0]    pix_x,
    input  logic [Y_W-1:0]    pix_y,
    output logic              ntsc_flag,
    output logic [ADDR_W-1:0] ntsc_addr,
    output logic [DATA_W-1:0] ntsc_data,
    input  logic              done_ntsc,
    output logic              frame_done,
    output logic              overflow
`ifdef NTSC_WRITE_DOUBLE_BUFFER_EN
    ,
    output logic              display_bank
`endif
);
    localparam int ENTRY_W = 1 + ADDR_W + DATA_W;
    localparam int unsigned HALF_LINE = $unsigned(H_ACTIVE / 2);
    localparam logic [X_W-1:0] X_LIMIT = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0] Y_LIMIT = Y_W'(V_ACTIVE);
    localparam logic [X_W-1:0] X_LAST  = X_W'(H_ACTIVE - 1);
    localparam logic [Y_W-1:0] Y_LAST  = Y_W'(V_ACTIVE - 1);

    pair_state_t         r_state;
    logic [PIX_W-1:0]    r_lo_half;
    logic                r_vld_p1;
    logic                r_last_p1;
    logic [ADDR_W-1:0]   r_addr_p1;
    logic [DATA_W-1:0]   r_data_p1;
    logic                r_overflow;
    logic                r_frame_done;

    logic                w_in_range;
    logic                w_even_p0;
    logic                w_odd_p0;
    logic                w_last_p0;
    logic [ADDR_W-1:0]   w_addr_p0;
    logic                w_push;
    logic                w_pop;
    logic                w_full;
    logic                w_empty;
    logic [FIFO_LOG:0]   w_count;
    logic [ENTRY_W-1:0]  w_fifo_in;
    logic [ENTRY_W-1:0]  w_fifo_out;
    logic                w_head_last;
    logic [ADDR_W-1:0]   w_head_addr;
    logic [DATA_W-1:0]   w_head_data;

`ifdef NTSC_WRITE_DOUBLE_BUFFER_EN
    logic                r_bank;
    logic                r_display_bank;
`endif

    // p0: filter the incoming strobe and derive word address and frame tag
    assign w_in_range = pix_valid && (pix_x < X_LIMIT) && (pix_y < Y_LIMIT);
    assign w_even_p0  = w_in_range && !pix_x[0];
    assign w_odd_p0   = w_in_range && pix_x[0];
    assign w_last_p0  = (pix_x == X_LAST) && (pix_y == Y_LAST);

    always_comb begin
        w_addr_p0 = ADDR_W'(word_index(pix_x, pix_y, HALF_LINE));
`ifdef NTSC_WRITE_DOUBLE_BUFFER_EN
        w_addr_p0[ADDR_W-1] = r_bank;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_lo_half <= '0;
            r_vld_p1  <= 1'b0;
        end else begin
            r_vld_p1 <= 1'b0;
            if (w_even_p0) begin
                r_lo_half <= pix_ycrcb;
                r_state   <= ST_HAVE_LO;
            end else if (w_odd_p0) begin
                r_vld_p1 <= 1'b1;
                r_state  <= ST_PUSH;
            end else if (r_state == ST_PUSH) begin
                r_state <= ST_IDLE;
            end
        end
    end

    // An odd pixel without a preceding even one deliberately reuses the stale low half
    always_ff @(posedge clock) begin
        if (w_odd_p0) begin
            r_last_p1 <= w_last_p0;
            r_addr_p1 <= w_addr_p0;
            r_data_p1 <= {pix_ycrcb, r_lo_half};
        end
    end

    // p1: push the packed word into the queue
    assign w_fifo_in = {r_last_p1, r_addr_p1, r_data_p1};
    assign w_pop     = done_ntsc && !w_empty;
    assign w_push    = r_vld_p1 && (!w_full || w_pop);

    ntsc_write_fifo #(
        .WIDTH    (ENTRY_W),
        .FIFO_LOG (FIFO_LOG)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_fifo_in),
        .o_data  (w_fifo_out),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_head_last = w_fifo_out[ENTRY_W-1];
    assign w_head_addr = w_fifo_out[DATA_W +: ADDR_W];
    assign w_head_data = w_fifo_out[DATA_W-1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_overflow   <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            if (r_vld_p1 && w_full && !w_pop)
                r_overflow <= 1'b1;
            r_frame_done <= w_pop && w_head_last;
        end
    end

`ifdef NTSC_WRITE_DOUBLE_BUFFER_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bank         <= 1'b0;
            r_display_bank <= 1'b0;
        end else if (w_pop && w_head_last) begin
            r_bank         <= ~r_bank;
            r_display_bank <= w_head_addr[ADDR_W-1];
        end
    end

    assign display_bank = r_display_bank;
`endif

    // Head is masked while empty so the bus idles at zero
    assign ntsc_flag  = (w_count != '0);
    assign ntsc_addr  = ntsc_flag ? w_head_addr : '0;
    assign ntsc_data  = ntsc_flag ? w_head_data : '0;
    assign frame_done = r_frame_done;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_ntsc_frame_writer.sv
// Randomized and directed bench for ntsc_frame_writer against a queue-based reference model.
`timescale 1ns/1ps
module tb_ntsc_frame_writer;
    localparam int HA    = 640;
    localparam int VA    = 480;
    localparam int AW    = 19;
    localparam int DEPTH = 8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pix_valid = 1'b0;
    logic [17:0] pix_ycrcb = '0;
    logic [9:0]  pix_x = '0;
    logic [8:0]  pix_y = '0;
    logic        done_ntsc = 1'b0;
    logic        ntsc_flag;
    logic [18:0] ntsc_addr;
    logic [35:0] ntsc_data;
    logic        frame_done;
    logic        overflow;
`ifdef NTSC_WRITE_DOUBLE_BUFFER_EN
    logic        display_bank;
`endif

    ntsc_frame_writer dut (
        .clock      (clock),
        .reset      (reset),
        .pix_valid  (pix_valid),
        .pix_ycrcb  (pix_ycrcb),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .ntsc_flag  (ntsc_flag),
        .ntsc_addr  (ntsc_addr),
        .ntsc_data  (ntsc_data),
        .done_ntsc  (done_ntsc),
        .frame_done (frame_done),
        .overflow   (overflow)
`ifdef NTSC_WRITE_DOUBLE_BUFFER_EN
        ,
        .display_bank (display_bank)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic        last;
        logic [18:0] addr;
        logic [35:0] data;
    } ent_t;

    ent_t        q[$];
    logic        pend_v = 1'b0;
    ent_t        pend_e = '0;
    logic [17:0] m_lo = '0;
    logic        m_ovf = 1'b0;
    logic        m_fd = 1'b0;
`ifdef NTSC_WRITE_DOUBLE_BUFFER_EN
    logic        m_bank = 1'b0;
    logic        m_disp = 1'b0;
`endif
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: one clock edge in terms of queue operations on the word stream
    task automatic model_edge();
        ent_t head;
        ent_t nxt;
        logic nxt_v;
        logic fd;
        logic in_rng;
        int   a;
        head  = '0;
        nxt   = '0;
        nxt_v = 1'b0;
        fd    = 1'b0;
        if (reset) begin
            q.delete();
            pend_v = 1'b0;
            m_lo   = '0;
            m_ovf  = 1'b0;
            m_fd   = 1'b0;
`ifdef NTSC_WRITE_DOUBLE_BUFFER_EN
            m_bank = 1'b0;
            m_disp = 1'b0;
`endif
            return;
        end
        if (done_ntsc && q.size() > 0) begin
            head = q.pop_front();
            fd   = head.last;
        end
        if (pend_v) begin
            if (q.size() < DEPTH) q.push_back(pend_e);
            else m_ovf = 1'b1;
        end
        in_rng = pix_valid && (int'(pix_x) < HA) && (int'(pix_y) < VA);
        if (in_rng && pix_x[0]) begin
            a         = int'(pix_y) * (HA / 2) + int'(pix_x) / 2;
            nxt_v     = 1'b1;
            nxt.last  = (int'(pix_x) == HA - 1) && (int'(pix_y) == VA - 1);
            nxt.addr  = 19'(a);
`ifdef NTSC_WRITE_DOUBLE_BUFFER_EN
            nxt.addr[AW-1] = m_bank;
`endif
            nxt.data  = {pix_ycrcb, m_lo};
        end
        if (in_rng && !pix_x[0]) m_lo = pix_ycrcb;
        pend_v = nxt_v;
        pend_e = nxt;
        m_fd   = fd;
`ifdef NTSC_WRITE_DOUBLE_BUFFER_EN
        if (fd) begin
            m_disp = head.addr[AW-1];
            m_bank = ~m_bank;
        end
`endif
    endtask

    task automatic check_outputs();
        chk("flag", 64'(ntsc_flag), 64'(q.size() != 0));
        if (q.size() != 0) begin
            chk("head_addr", 64'(ntsc_addr), 64'(q[0].addr));
            chk("head_data", 64'(ntsc_data), 64'(q[0].data));
        end
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("frame_done", 64'(frame_done), 64'(m_fd));
`ifdef NTSC_WRITE_DOUBLE_BUFFER_EN
        chk("display_bank", 64'(display_bank), 64'(m_disp));
`endif
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check_outputs();
    endtask

    task automatic pix(input int x, input int y, input logic [17:0] d, input logic dn);
        pix_valid = 1'b1;
        pix_x     = 10'(x);
        pix_y     = 9'(y);
        pix_ycrcb = d;
        done_ntsc = dn;
        tick();
        pix_valid = 1'b0;
        done_ntsc = 1'b0;
    endtask

    task automatic idle(input int n, input logic dn);
        done_ntsc = dn;
        repeat (n) tick();
        done_ntsc = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int pct;
        do_reset();
        chk("rst_flag", 64'(ntsc_flag), 64'(0));
        chk("rst_addr", 64'(ntsc_addr), 64'(0));
        chk("rst_data", 64'(ntsc_data), 64'(0));
        chk("rst_ovf", 64'(overflow), 64'(0));
        chk("rst_fd", 64'(frame_done), 64'(0));

        // Pair packing
        pix(0, 0, 18'h00AAA, 1'b0);
        pix(1, 0, 18'h15555, 1'b0);
        idle(1, 1'b0);
        chk("pair_flag", 64'(ntsc_flag), 64'(1));
        chk("pair_addr", 64'(ntsc_addr), 64'(0));
        chk("pair_data", 64'(ntsc_data), 64'({18'h15555, 18'h00AAA}));
        idle(1, 1'b1);
        chk("pair_flag_drop", 64'(ntsc_flag), 64'(0));

        // Address math and out-of-range filter
        pix(638, 2, 18'($urandom), 1'b0);
        pix(639, 2, 18'($urandom), 1'b0);
        idle(1, 1'b0);
        chk("addr_959", 64'(ntsc_addr), 64'(959));
        pix(700, 2, 18'($urandom), 1'b0);
        pix(701, 2, 18'($urandom), 1'b0);
        idle(2, 1'b0);
        idle(1, 1'b1);
        chk("x700_nopush", 64'(ntsc_flag), 64'(0));

        // Backpressure: 10 pairs into an 8-deep queue
        for (int k = 0; k < 10; k++) begin
            pix(2 * k, 7, 18'($urandom), 1'b0);
            pix(2 * k + 1, 7, 18'($urandom), 1'b0);
        end
        idle(1, 1'b0);
        chk("bp_overflow", 64'(overflow), 64'(1));
        idle(DEPTH, 1'b1);
        chk("bp_drained", 64'(ntsc_flag), 64'(0));

        // Reset mid-queue, including a frame-final word
        for (int k = 0; k < 3; k++) begin
            pix(2 * k, 9, 18'($urandom), 1'b0);
            pix(2 * k + 1, 9, 18'($urandom), 1'b0);
        end
        pix(638, 479, 18'($urandom), 1'b0);
        pix(639, 479, 18'($urandom), 1'b0);
        idle(1, 1'b0);
        do_reset();
        chk("rstq_flag", 64'(ntsc_flag), 64'(0));
        chk("rstq_ovf", 64'(overflow), 64'(0));
        idle(3, 1'b1);
        chk("rstq_no_fd", 64'(frame_done), 64'(0));
        chk("rstq_flag_after", 64'(ntsc_flag), 64'(0));

        // Full queue with coincident push and pop
        for (int k = 0; k < DEPTH; k++) begin
            pix(2 * k, 11, 18'($urandom), 1'b0);
            pix(2 * k + 1, 11, 18'($urandom), 1'b0);
        end
        idle(1, 1'b0);
        pix(40, 11, 18'($urandom), 1'b0);
        pix(41, 11, 18'($urandom), 1'b0);
        idle(1, 1'b1);
        chk("full_simul_ovf", 64'(overflow), 64'(0));
        idle(DEPTH - 1, 1'b1);
        chk("full_cnt_last", 64'(ntsc_flag), 64'(1));
        idle(1, 1'b1);
        chk("full_drained", 64'(ntsc_flag), 64'(0));

        // Frame end
        pix(638, 479, 18'($urandom), 1'b0);
        pix(639, 479, 18'($urandom), 1'b0);
        idle(1, 1'b0);
        chk("fd_early", 64'(frame_done), 64'(0));
        idle(1, 1'b1);
        chk("fd_pulse", 64'(frame_done), 64'(1));
        idle(1, 1'b0);
        chk("fd_one_cycle", 64'(frame_done), 64'(0));

        // Randomized traffic with varying drain rate
        for (int i = 0; i < 3000; i++) begin
            pct       = 10 + 20 * ((i / 500) % 5);
            reset     = ($urandom_range(0, 299) == 0);
            pix_valid = ($urandom_range(0, 99) < 60);
            case ($urandom_range(0, 9))
                0: begin
                    pix_x = 10'(638 + $urandom_range(0, 1));
                    pix_y = 9'(479);
                end
                1: begin
                    pix_x = 10'($urandom_range(640, 1023));
                    pix_y = 9'($urandom_range(0, 479));
                end
                2: begin
                    pix_x = 10'($urandom_range(0, 639));
                    pix_y = 9'($urandom_range(480, 511));
                end
                default: begin
                    pix_x = 10'($urandom_range(0, 639));
                    pix_y = 9'($urandom_range(0, 479));
                end
            endcase
            pix_ycrcb = 18'($urandom);
            done_ntsc = ($urandom_range(0, 99) < pct);
            tick();
        end
        reset     = 1'b0;
        pix_valid = 1'b0;
        done_ntsc = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
